// File: rtl/fpga_feature_engine.sv
// Feature producer for the inference path: book imbalance via an 11-step restoring
// divider and a sliding-window trade count, published together on a feat_valid strobe.
module fpga_feature_engine #(
  parameter int SLOT_CYCLES = 250000,
  parameter int NUM_SLOTS   = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bk_valid,
  output logic        bk_ready,
  input  logic [31:0] bid_vol,
  input  logic [31:0] ask_vol,
  input  logic        trade_pulse,
  output logic        feat_valid,
  output logic [15:0] book_imbalance_fixed,
  output logic [7:0]  trade_intensity
);

  localparam int SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int PW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_CYCLES - 1);
  localparam logic [PW-1:0] PTR_LAST  = PW'(NUM_SLOTS - 1);
  localparam logic [3:0]    ITER_LAST = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // sliding window
  logic [SW-1:0]                slot_cnt;
  logic [PW-1:0]                ptr;
  logic [7:0]                   cur_cnt;
  logic [15:0]                  sum;
  logic [NUM_SLOTS-1:0][7:0]    ring;
  logic                         slot_end;

  // divider / publication
  state_t        state, nxt;
  logic [32:0]   den;
  logic [33:0]   rem, trial, rem_nxt;
  logic [10:0]   quo;
  logic          q_bit;
  logic [3:0]    iter;
  logic [7:0]    snap;

  assign slot_end = (slot_cnt == SLOT_LAST);

  // A pulse on the closing cycle seeds the new slot rather than the closing one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt <= '0;
      ptr      <= '0;
      cur_cnt  <= '0;
      sum      <= '0;
      ring     <= '0;
    end else if (slot_end) begin
      slot_cnt  <= '0;
      sum       <= sum - 16'(ring[ptr]) + 16'(cur_cnt);
      ring[ptr] <= cur_cnt;
      ptr       <= (ptr == PTR_LAST) ? '0 : ptr + PW'(1);
      cur_cnt   <= {7'd0, trade_pulse};
    end else begin
      slot_cnt <= slot_cnt + SW'(1);
      if (trade_pulse && cur_cnt != 8'hFF)
        cur_cnt <= cur_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (bk_valid) nxt = DIV;
      DIV:     if (iter == ITER_LAST) nxt = OUT;
      OUT:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    bk_ready = (state == IDLE);
  end

  // First step compares bid directly against D; later steps shift the remainder first.
  always_comb begin
    trial   = (iter == 4'd0) ? rem : {rem[32:0], 1'b0};
    q_bit   = (trial >= {1'b0, den});
    rem_nxt = q_bit ? (trial - {1'b0, den}) : trial;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      den                  <= '0;
      rem                  <= '0;
      quo                  <= '0;
      iter                 <= '0;
      snap                 <= '0;
      feat_valid           <= 1'b0;
      book_imbalance_fixed <= '0;
      trade_intensity      <= '0;
    end else begin
      feat_valid <= 1'b0;
      case (state)
        IDLE: if (bk_valid) begin
          den  <= {1'b0, bid_vol} + {1'b0, ask_vol};
          rem  <= {2'b00, bid_vol};
          quo  <= '0;
          iter <= '0;
          snap <= (sum > 16'd255) ? 8'hFF : sum[7:0];
        end
        DIV: begin
          rem  <= rem_nxt;
          quo  <= {quo[9:0], q_bit};
          iter <= iter + 4'd1;
        end
        OUT: begin
          // empty book reads as balanced
          book_imbalance_fixed <= (den == 33'd0) ? 16'd512 : {5'b00000, quo};
          trade_intensity      <= snap;
          feat_valid           <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_feature_engine.sv
// Bench for fpga_feature_engine: slot-level window model plus exact-division model,
// checked every cycle, with directed literal checks for the named scenarios.
module tb_fpga_feature_engine;

  localparam int S  = 8;   // 8-cycle slots so five trades fit one slot
  localparam int NS = 4;
  localparam int SAT_S = 400;

  logic        clk, rst;
  logic        bk_valid, sat_bk_valid;
  logic [31:0] bid, ask;
  logic        trade_pulse, sat_pulse;
  logic        bk_ready, feat_valid, sat_bk_ready, sat_feat_valid;
  logic [15:0] book_imbalance_fixed, sat_imb;
  logic [7:0]  trade_intensity, sat_ti;

  int n_tests = 0;
  int n_fail  = 0;

  fpga_feature_engine #(.SLOT_CYCLES(S), .NUM_SLOTS(NS)) dut (
    .clk(clk), .rst(rst), .bk_valid(bk_valid), .bk_ready(bk_ready),
    .bid_vol(bid), .ask_vol(ask), .trade_pulse(trade_pulse),
    .feat_valid(feat_valid), .book_imbalance_fixed(book_imbalance_fixed),
    .trade_intensity(trade_intensity)
  );

  fpga_feature_engine #(.SLOT_CYCLES(SAT_S), .NUM_SLOTS(NS)) dut_sat (
    .clk(clk), .rst(rst), .bk_valid(sat_bk_valid), .bk_ready(sat_bk_ready),
    .bid_vol(bid), .ask_vol(ask), .trade_pulse(sat_pulse),
    .feat_valid(sat_feat_valid), .book_imbalance_fixed(sat_imb),
    .trade_intensity(sat_ti)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  int cyc = 0;          // cycle index since reset release
  int busy = 0;         // first cycle in which a snapshot is accepted again
  int tr [0:1023];      // trades per slot; a trade in cycle t belongs to slot (t+1)/S
  int q_due[$], q_imb[$], q_ti[$];
  int last_imb = 0, last_ti = 0;
  int feat_cnt = 0;
  bit exp_fv;

  function automatic int model_imb(input longint unsigned b, input longint unsigned a);
    if (b + a == 0) return 512;
    return int'((b * 1024) / (b + a));
  endfunction

  // slots completed before cycle c are 0 .. c/S-1; window is the last NS of them
  function automatic int model_snap(input int c);
    int last, s;
    last = c / S - 1;
    s = 0;
    for (int j = last - NS + 1; j <= last; j++)
      if (j >= 0 && j < 1024) s += (tr[j] > 255) ? 255 : tr[j];
    return (s > 255) ? 255 : s;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      cyc = 0; busy = 0; last_imb = 0; last_ti = 0;
      q_due.delete(); q_imb.delete(); q_ti.delete();
      foreach (tr[i]) tr[i] = 0;
    end else begin
      if (trade_pulse && (cyc + 1) / S < 1024) tr[(cyc + 1) / S]++;
      if (bk_valid && cyc >= busy) begin
        q_due.push_back(cyc + 12);
        q_imb.push_back(model_imb(bid, ask));
        q_ti.push_back(model_snap(cyc));
        busy = cyc + 13;
      end
      cyc++;
      #1;
      exp_fv = (q_due.size() > 0) && (q_due[0] == cyc - 1);
      chk("cyc_feat_valid", feat_valid, exp_fv);
      if (exp_fv) begin
        void'(q_due.pop_front());
        last_imb = q_imb.pop_front();
        last_ti  = q_ti.pop_front();
      end
      if (feat_valid) feat_cnt++;
      chk("cyc_imbalance", book_imbalance_fixed, last_imb);
      chk("cyc_intensity", trade_intensity, last_ti);
      chk("cyc_bk_ready", bk_ready, cyc >= busy);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_cyc(input int t);
    int n;
    n = 0;
    while (cyc < t && n < 5000) begin @(negedge clk); n++; end
  endtask

  task automatic do_snap(input bit sat, input logic [31:0] b, input logic [31:0] a,
                         output int imb, output int ti, output int lat, output int lowc);
    int n;
    n = 0; lowc = 0; imb = -1; ti = -1;
    while (!(sat ? sat_bk_ready : bk_ready) && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      n_tests++; n_fail++;
      $display("FAIL ready_timeout: bk_ready still 0 after %0d cycles", n);
    end
    bid = b; ask = a;
    if (sat) sat_bk_valid = 1'b1; else bk_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      if (n == 0) begin bk_valid = 1'b0; sat_bk_valid = 1'b0; end
      n++;
      if (!(sat ? sat_bk_ready : bk_ready)) lowc++;
    end while (!(sat ? sat_feat_valid : feat_valid) && n < 40);
    lat = n;
    if (!(sat ? sat_feat_valid : feat_valid)) begin
      n_tests++; n_fail++;
      $display("FAIL feat_timeout: no feat_valid within %0d cycles", n);
    end else begin
      imb = sat ? int'(sat_imb) : int'(book_imbalance_fixed);
      ti  = sat ? int'(sat_ti)  : int'(trade_intensity);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int imb, ti, lat, lowc, m, p, a, fc0;
    rst = 1'b1; bk_valid = 1'b0; sat_bk_valid = 1'b0;
    bid = '0; ask = '0; trade_pulse = 1'b0; sat_pulse = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_bk_ready", bk_ready, 1);
    chk("reset_feat_valid", feat_valid, 0);
    chk("reset_imb", book_imbalance_fixed, 0);
    chk("reset_ti", trade_intensity, 0);
    chk("reset_sat_ti", sat_ti, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // latency and basic ratio
    do_snap(0, 600, 400, imb, ti, lat, lowc);
    chk("t1_imb_614", imb, 614);
    chk("t1_ti", ti, 0);
    chk("t1_latency", lat, 13);
    chk("t1_ready_low_cycles", lowc, 12);

    // edge ratios
    do_snap(0, 0, 0, imb, ti, lat, lowc);                       chk("t2_zero_zero", imb, 512);
    do_snap(0, 5, 0, imb, ti, lat, lowc);                       chk("t2_all_bid", imb, 1024);
    do_snap(0, 0, 7, imb, ti, lat, lowc);                       chk("t2_all_ask", imb, 0);
    do_snap(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, imb, ti, lat, lowc); chk("t2_max_max", imb, 512);

    // window: 3 trades in slot m, 5 in slot m+1
    m = cyc / S + 1;
    wait_cyc(S * m);
    trade_pulse = 1'b1; repeat (3) @(negedge clk); trade_pulse = 1'b0;
    wait_cyc(S * m + 7);
    trade_pulse = 1'b1; repeat (5) @(negedge clk); trade_pulse = 1'b0;
    wait_cyc(S * m + 18);
    do_snap(0, 1, 1, imb, ti, lat, lowc);  chk("t3_window_8", ti, 8);
    wait_cyc(S * m + 42);
    do_snap(0, 1, 3, imb, ti, lat, lowc);  chk("t3_window_5", ti, 5);
    chk("t3_imb_256", imb, 256);
    wait_cyc(S * m + 50);
    do_snap(0, 3, 1, imb, ti, lat, lowc);  chk("t3_window_0", ti, 0);

    // trade on the closing cycle belongs to the next slot
    p = cyc / S + 1;
    wait_cyc(S * p + 7);
    trade_pulse = 1'b1; @(negedge clk); trade_pulse = 1'b0;
    wait_cyc(S * p + 9);
    do_snap(0, 2, 2, imb, ti, lat, lowc);  chk("t5_boundary_not_closing", ti, 0);
    wait_cyc(S * p + 24);
    do_snap(0, 2, 2, imb, ti, lat, lowc);  chk("t5_boundary_next_slot", ti, 1);

    // offer while busy is dropped
    fc0 = feat_cnt;
    while (!bk_ready) @(negedge clk);
    bid = 100; ask = 300; bk_valid = 1'b1;
    @(negedge clk); bk_valid = 1'b0;
    repeat (4) @(negedge clk);
    bid = 1; ask = 0; bk_valid = 1'b1;
    @(negedge clk); bk_valid = 1'b0;
    repeat (25) @(negedge clk);
    chk("t5_busy_single_feat", feat_cnt - fc0, 1);
    chk("t5_busy_first_kept", book_imbalance_fixed, 256);

    // reset mid-division with a fully populated ring
    trade_pulse = 1'b1; repeat (40) @(negedge clk); trade_pulse = 1'b0;
    repeat (10) @(negedge clk);
    while (!bk_ready) @(negedge clk);
    bid = 9; ask = 1; bk_valid = 1'b1;
    @(negedge clk); bk_valid = 1'b0;
    repeat (5) @(negedge clk);
    fc0 = feat_cnt;
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_feat_valid", feat_valid, 0);
    chk("t6_rst_imb", book_imbalance_fixed, 0);
    chk("t6_rst_ti", trade_intensity, 0);
    chk("t6_rst_bk_ready", bk_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_cyc(20);
    chk("t6_no_feat_after_abort", feat_cnt - fc0, 0);
    do_snap(0, 1, 1, imb, ti, lat, lowc);  chk("t6_window_cleared", ti, 0);
    m = cyc / S + 1;
    wait_cyc(S * m);
    trade_pulse = 1'b1; repeat (2) @(negedge clk); trade_pulse = 1'b0;
    wait_cyc(S * m + 10);
    do_snap(0, 1, 1, imb, ti, lat, lowc);  chk("t6_restart_count", ti, 2);

    // per-slot saturation on the long-slot instance
    a = cyc / SAT_S + 1;
    wait_cyc(SAT_S * a);
    sat_pulse = 1'b1; repeat (300) @(negedge clk); sat_pulse = 1'b0;
    wait_cyc(SAT_S * a + 410);
    do_snap(1, 1, 1, imb, ti, lat, lowc);  chk("t4_slot_sat_255", ti, 255);
    wait_cyc(SAT_S * (a + 1));
    sat_pulse = 1'b1; repeat (300) @(negedge clk); sat_pulse = 1'b0;
    wait_cyc(SAT_S * (a + 1) + 410);
    do_snap(1, 1, 1, imb, ti, lat, lowc);  chk("t4_sum510_sat_255", ti, 255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
